// File: rtl/light_pkg.sv
// Shared types and default timing for the lamp controller.
// The state enum is shared with anything that needs to decode lamp_controller's mode.
package light_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        ON_AUTO   = 2'd1,
        ON_MANUAL = 2'd2
    } lamp_state_t;

    localparam int DEBOUNCE_T_DEFAULT   = 50000;
    localparam int LONG_PRESS_T_DEFAULT = 1000000;

endpackage

// File: rtl/push_debounce.sv
// Two-flop synchronizer followed by a consecutive-disagreement debounce counter.
// dout only moves once the synchronized level has disagreed with it for DEBOUNCE_T cycles in a row.
module push_debounce
    import light_pkg::*;
#(
    parameter int DEBOUNCE_T = DEBOUNCE_T_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_T > 1) ? $clog2(DEBOUNCE_T) : 1;

    logic          meta_reg;
    logic          sync_reg;
    logic          db_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            db_reg   <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            // Any agreeing cycle restarts the count, so short glitches never accumulate.
            if (sync_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(DEBOUNCE_T - 1)) begin
                db_reg  <= sync_reg;
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign dout = db_reg;

endmodule

// File: rtl/lamp_controller.sv
// Lamp on/off controller: debounced push-button, short/long press classification
// and a three-mode lamp FSM that also gates the auto-shutdown timer.
module lamp_controller
    import light_pkg::*;
#(
    parameter int DEBOUNCE_T   = DEBOUNCE_T_DEFAULT,
    parameter int LONG_PRESS_T = LONG_PRESS_T_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic auto_off,
    output logic lamp,
    output logic timer_en
);

    localparam int HW = $clog2(LONG_PRESS_T + 1);

    logic          db;
    logic          db_prev_reg;
    logic [HW-1:0] hold_reg;
    logic          long_ev;
    logic          short_ev;
    lamp_state_t   state_reg;

    push_debounce #(
        .DEBOUNCE_T(DEBOUNCE_T)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (push),
        .dout (db)
    );

    // Hold counter saturates so a very long press cannot wrap into a second long event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_prev_reg <= 1'b0;
            hold_reg    <= '0;
        end else begin
            db_prev_reg <= db;
            if (!db) begin
                hold_reg <= '0;
            end else if (hold_reg != HW'(LONG_PRESS_T)) begin
                hold_reg <= hold_reg + 1'b1;
            end
        end
    end

    assign long_ev  = db && (hold_reg == HW'(LONG_PRESS_T - 1));
    // On the falling cycle the counter still holds the press length; it clears one edge later.
    assign short_ev = db_prev_reg && !db && (hold_reg < HW'(LONG_PRESS_T));

    // A press always takes priority over auto_off when both land in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= OFF;
        end else begin
            case (state_reg)
                OFF: begin
                    if (long_ev) begin
                        state_reg <= ON_MANUAL;
                    end else if (short_ev) begin
                        state_reg <= ON_AUTO;
                    end
                end
                ON_AUTO: begin
                    if (long_ev) begin
                        state_reg <= ON_MANUAL;
                    end else if (short_ev || auto_off) begin
                        state_reg <= OFF;
                    end
                end
                ON_MANUAL: begin
                    if (long_ev) begin
                        state_reg <= ON_AUTO;
                    end else if (short_ev) begin
                        state_reg <= OFF;
                    end
                end
                default: state_reg <= OFF;
            endcase
        end
    end

    assign lamp     = (state_reg != OFF);
    assign timer_en = (state_reg == ON_AUTO);

endmodule
